// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_arbiter
// Purpose  : Round-robin arbiter that shares one barrier door between several
//            entry/exit lanes, sequences open/hold/close and keeps the lot
//            occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_arbiter #(
    parameter int CAPACITY  = 4,
    parameter int LANES     = 4,
    parameter int DOOR_HOLD = 8,
    parameter int CW        = $clog2(CAPACITY + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [LANES-1:0] req,
    input  logic [LANES-1:0] dir,
    input  logic             passed,
    output logic [LANES-1:0] grant,
    output logic             door_open,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             timeout
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_CLOSE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [LANES-1:0] grant_q,     grant_d;
    logic             door_open_q, door_open_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             timeout_q,   timeout_d;
    logic [PW-1:0]    ptr_q,       ptr_d;
    logic [TW-1:0]    timer_q,     timer_d;
    logic             entry_q,     entry_d;   // direction latched at grant

    logic [LANES-1:0] w_eligible;
    logic             w_found;
    logic [PW-1:0]    w_sel;
    logic [PW-1:0]    w_sel_next;
    logic [PW:0]      w_sum;

    assign full  = (count_q == CW'(CAPACITY));
    assign empty = (count_q == '0);

    // Eligibility filter and round-robin pick of the first eligible lane from ptr
    always_comb begin
        w_eligible = '0;
        w_found    = 1'b0;
        w_sel      = '0;
        w_sum      = '0;
        for (int i = 0; i < LANES; i++) begin
            w_eligible[i] = req[i] && ((dir[i] && !full) || (!dir[i] && !empty));
        end
        for (int k = 0; k < LANES; k++) begin
            w_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(LANES)) begin
                w_sum = w_sum - (PW+1)'(LANES);
            end
            if (!w_found && w_eligible[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[PW-1:0];
            end
        end
        w_sel_next = (w_sel == PW'(LANES - 1)) ? '0 : w_sel + 1'b1;
    end

    // Gate sequencing: next state, grant/door outputs, count and timer updates
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        door_open_d = door_open_q;
        count_d     = count_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        entry_d     = entry_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d     = LANES'(1) << w_sel;
                    door_open_d = 1'b1;
                    timer_d     = '0;
                    ptr_d       = w_sel_next;
                    entry_d     = dir[w_sel];
                    state_d     = S_OPEN;
                end
            end
            S_OPEN: begin
                if (passed) begin
                    // Guards keep the count from wrapping even if eligibility is bypassed
                    if (entry_q && !full) begin
                        count_d = count_q + 1'b1;
                    end else if (!entry_q && !empty) begin
                        count_d = count_q - 1'b1;
                    end
                    grant_d     = '0;
                    door_open_d = 1'b0;
                    state_d     = S_CLOSE;
                end else if (timer_q == TW'(DOOR_HOLD - 1)) begin
                    timeout_d   = 1'b1;
                    grant_d     = '0;
                    door_open_d = 1'b0;
                    state_d     = S_CLOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CLOSE: begin
                grant_d     = '0;
                door_open_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                grant_d     = '0;
                door_open_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset; in-flight vehicle is dropped
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            door_open_q <= 1'b0;
            count_q     <= '0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            timer_q     <= '0;
            entry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            door_open_q <= door_open_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            entry_q     <= entry_d;
        end
    end

    assign grant     = grant_q;
    assign door_open = door_open_q;
    assign count     = count_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_gate_arbiter
// Purpose  : Directed and random stimulus against a behavioural gate model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_gate_arbiter;

    localparam int CAPACITY  = 4;
    localparam int LANES     = 4;
    localparam int DOOR_HOLD = 8;
    localparam int CW        = $clog2(CAPACITY + 1);

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [LANES-1:0] req = '0;
    logic [LANES-1:0] dir = '0;
    logic             passed = 1'b0;
    logic [LANES-1:0] grant;
    logic             door_open;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: which lane is being served, how long the door has
    // been open, whether the door is in its closing cycle, and the lot count.
    int m_count, m_ptr, m_lane, m_elapsed;
    bit m_open, m_closing, m_entry, m_timeout;

    parking_gate_arbiter #(
        .CAPACITY (CAPACITY),
        .LANES    (LANES),
        .DOOR_HOLD(DOOR_HOLD),
        .CW       (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .dir      (dir),
        .passed   (passed),
        .grant    (grant),
        .door_open(door_open),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .timeout  (timeout)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_count = 0; m_ptr = 0; m_lane = 0; m_elapsed = 0;
        m_open = 0; m_closing = 0; m_entry = 0; m_timeout = 0;
    endtask

    task automatic model_step(input logic [LANES-1:0] r, input logic [LANES-1:0] d, input logic p);
        m_timeout = 0;
        if (m_open) begin
            if (p) begin
                m_count  = m_count + (m_entry ? 1 : -1);
                m_open   = 0;
                m_closing = 1;
            end else if (m_elapsed == DOOR_HOLD - 1) begin
                m_timeout = 1;
                m_open    = 0;
                m_closing = 1;
            end else begin
                m_elapsed++;
            end
        end else if (m_closing) begin
            m_closing = 0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                int i;
                i = (m_ptr + k) % LANES;
                if (!m_open && r[i] && (d[i] ? (m_count < CAPACITY) : (m_count > 0))) begin
                    m_open    = 1;
                    m_lane    = i;
                    m_entry   = d[i];
                    m_elapsed = 0;
                    m_ptr     = (i + 1) % LANES;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [LANES-1:0] eg;
        eg = m_open ? LANES'(1 << m_lane) : '0;
        chk("grant",     32'(grant),     32'(eg));
        chk("door_open", 32'(door_open), 32'(m_open));
        chk("count",     32'(count),     32'(m_count));
        chk("full",      32'(full),      32'(m_count == CAPACITY));
        chk("empty",     32'(empty),     32'(m_count == 0));
        chk("timeout",   32'(timeout),   32'(m_timeout));
    endtask

    // One clock: drive inputs, let the edge sample them, advance model, compare.
    task automatic tick(input logic [LANES-1:0] r, input logic [LANES-1:0] d, input logic p);
        req = r; dir = d; passed = p;
        @(posedge CLK);
        model_step(r, d, p);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic pulse_reset();
        #2 RST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic serve(input logic [LANES-1:0] r, input logic [LANES-1:0] d, input int hold);
        tick(r, d, 1'b0);
        repeat (hold) tick(r, d, 1'b0);
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b0);
    endtask

    initial begin
        logic [LANES-1:0] seen[$];
        logic [LANES-1:0] prev_g;
        logic [LANES-1:0] rr, rd;
        int doors, tos, to_closed, start_cnt;
        bit rp;

        // Reset state
        model_reset();
        #1 check_all();
        @(negedge CLK);
        RST = 1'b1;

        // Single entry on lane 0, passed on third open cycle
        tick('0, '0, 1'b0);
        tick(4'b0001, 4'b0001, 1'b0);
        chk("s1_grant", 32'(grant), 32'h1);
        tick('0, '0, 1'b0);
        tick('0, '0, 1'b0);
        chk("s1_door_held", 32'(door_open), 32'h1);
        tick('0, '0, 1'b1);
        chk("s1_count", 32'(count), 32'h1);
        chk("s1_door_closed", 32'(door_open), 32'h0);
        chk("s1_empty", 32'(empty), 32'h0);
        tick('0, '0, 1'b0);

        // All lanes request entry continuously until the lot fills
        pulse_reset();
        prev_g = '0;
        for (int c = 0; c < 28; c++) begin
            tick(4'b1111, 4'b1111, m_open && (m_elapsed == 1));
            if (grant != '0 && prev_g == '0) seen.push_back(grant);
            prev_g = grant;
        end
        chk("s2_ngrants", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("s2_order", 32'(seen[i]), 32'(1 << i));
        chk("s2_full", 32'(full), 32'h1);
        chk("s2_count", 32'(count), 32'd4);

        // Full lot: exit on lane 3 wins over entry on lane 2 despite ptr
        serve(4'b0010, 4'b0000, 1);
        serve(4'b0010, 4'b0010, 1);
        tick(4'b1100, 4'b0100, 1'b0);
        chk("s3_exit_wins", 32'(grant), 32'h8);
        tick(4'b1100, 4'b0100, 1'b1);
        chk("s3_count", 32'(count), 32'd3);
        chk("s3_not_full", 32'(full), 32'h0);
        tick(4'b1100, 4'b0100, 1'b0);
        tick(4'b1100, 4'b0100, 1'b0);
        chk("s3_lane2_next", 32'(grant), 32'h4);
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b0);

        // Hold expiry without passed: exactly DOOR_HOLD open cycles, then timeout
        start_cnt = int'(count);
        tick(4'b0001, 4'b0000, 1'b0);
        doors = int'(door_open); tos = 0; to_closed = 0;
        for (int c = 0; c < 12; c++) begin
            tick('0, '0, 1'b0);
            doors += int'(door_open);
            if (timeout) begin
                tos++;
                if (!door_open) to_closed++;
            end
        end
        chk("s4_door_cycles", 32'(doors), 32'(DOOR_HOLD));
        chk("s4_timeout_pulses", 32'(tos), 32'd1);
        chk("s4_timeout_closed", 32'(to_closed), 32'd1);
        chk("s4_count_same", 32'(count), 32'(start_cnt));

        // passed on the last hold cycle wins over expiry
        tick(4'b0001, 4'b0000, 1'b0);
        repeat (DOOR_HOLD - 1) tick('0, '0, 1'b0);
        tick('0, '0, 1'b1);
        chk("s4_pass_timeout", 32'(timeout), 32'h0);
        chk("s4_pass_count", 32'(count), 32'(start_cnt - 1));
        tick('0, '0, 1'b0);

        // Asynchronous reset in the middle of a hold
        tick(4'b0010, 4'b0010, 1'b0);
        tick('0, '0, 1'b0);
        chk("s6_pre_count", 32'(count), 32'd3);
        pulse_reset();
        chk("s6_grant", 32'(grant), 32'h0);
        chk("s6_door", 32'(door_open), 32'h0);
        chk("s6_count", 32'(count), 32'h0);

        // Exit at an empty lot is never granted; passed in IDLE is ignored
        for (int c = 0; c < 10; c++) tick(4'b0100, 4'b0000, c[0]);
        chk("s5_no_grant", 32'(grant), 32'h0);
        chk("s5_empty", 32'(empty), 32'h1);
        chk("s5_count", 32'(count), 32'h0);

        // First request after reset arbitrates from lane 0
        tick(4'b1111, 4'b1111, 1'b0);
        chk("s6_lane0_first", 32'(grant), 32'h1);
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b0);

        // Random traffic with occasional asynchronous resets
        for (int c = 0; c < 600; c++) begin
            rr = LANES'($urandom);
            rd = LANES'($urandom);
            rp = ($urandom_range(0, 3) == 0);
            tick(rr, rd, rp);
            if ($urandom_range(0, 79) == 0) pulse_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shared-gate controller for the parking lot: arbitrates several lane requests (entry or exit) onto a single barrier door, sequences door open/hold/close, and maintains the occupancy count. Entry grants are withheld while the lot is full and exit grants while it is empty. It sits between the lane sensors and the barrier actuator, replacing direct enter/exit wiring to the capacity tracker.

## Interface
- CAPACITY, 4: number of parking spaces; count saturates in [0, CAPACITY].
- LANES, 4: number of requesting lanes.
- DOOR_HOLD, 8: maximum cycles the door stays open awaiting `passed`; must be ≥ 2.
- CW, $clog2(CAPACITY+1): width of `count`.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- req  in  LANES  per-lane vehicle-waiting level.
- dir  in  LANES  per-lane direction: 1 = entry, 0 = exit. Sampled with `req`.
- passed  in  1  vehicle-cleared-gate pulse from the door sensor.
- grant  out  LANES  one-hot lane currently served. Registered.
- door_open  out  1  barrier open command. Registered.
- count  out  CW  occupied spaces. Registered.
- full  out  1  count == CAPACITY. Derived from the count register.
- empty  out  1  count == 0. Derived from the count register.
- timeout  out  1  one-cycle pulse when the hold expires without `passed`.

## Operation
- States: IDLE, OPEN, CLOSE.
- Eligible lane i: req[i] && ((dir[i] && !full) || (!dir[i] && !empty)).
- IDLE:
  - With no eligible lane, stay in IDLE.
  - Otherwise select the first eligible lane in round-robin order, starting at ptr and wrapping LANES-1 → 0.
  - On selection: set grant to that lane, set door_open=1, clear timer, set ptr = lane+1 mod LANES, go to OPEN.
- OPEN:
  - grant and door_open hold. Lane `req`/`dir` changes are ignored; direction is latched at grant.
  - passed=1: count +1 for an entry grant or −1 for an exit grant. Clear grant and door_open, go to CLOSE.
  - Otherwise, if timer == DOOR_HOLD-1: pulse timeout, count unchanged, clear grant and door_open, go to CLOSE.
  - Otherwise timer +1.
  - If passed and timer expiry coincide, passed wins: count is updated and timeout is not pulsed.
- CLOSE: one cycle with the door closed; grant=0; then go to IDLE. `passed` is ignored here and in IDLE.
- count never wraps. Eligibility guarantees no entry at CAPACITY and no exit at 0.
- Reset (asynchronous, any state including OPEN mid-hold) forces:
  - state=IDLE, grant=0, door_open=0, count=0, timeout=0, ptr=0, timer=0.
  - full=0, empty=1.
  - An in-flight vehicle is not counted.

## Timing
- Grant latency:
  - An eligible req sampled at edge k gives grant/door_open high after edge k.
  - This holds only if the block is in IDLE at edge k. A req arriving during OPEN/CLOSE waits.
- passed sampled at edge m:
  - count, full and empty are updated after edge m, and door_open goes low after edge m.
  - CLOSE occupies cycle m+1. The next grant is earliest after edge m+2, so the gate cycle is at least 3 cycles.
- With no passed, door_open stays high for exactly DOOR_HOLD cycles. timeout is high in the cycle following the last hold cycle, concurrent with CLOSE.
- Round-robin: a continuously requesting lane waits at most LANES-1 grants.
- full and empty are valid in the same cycle as the count they reflect.

## Test plan
- Reset, then lane 0 requests entry at cycle 2, passed at cycle 5 → grant=0001 and door_open=1 for cycles 3–5, count=1 from cycle 6, door closed cycle 6, empty=0.
- All 4 lanes request entry continuously, passed 2 cycles after each grant, CAPACITY=4 → grants in order lane 0,1,2,3; count reaches 4 and full=1; a further entry request gets no grant.
- count=4, lane 2 entry and lane 3 exit both requesting → lane 3 is granted despite ptr favouring lane 2; after passed, count=3 and full=0, then lane 2 is granted next.
- Grant with no passed, DOOR_HOLD=8 → door_open high for exactly 8 cycles, then a one-cycle timeout pulse with count unchanged. Repeat with passed on the 8th hold cycle → count updated, no timeout.
- Exit request at count=0 → never granted, empty stays 1. passed pulses while in IDLE → count unchanged.
- Assert RST low mid-OPEN with count=3 → grant=0, door_open=0 and count=0 immediately (asynchronous); after release, the first request is arbitrated from lane 0.
